// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the slave response FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ERR1   = 2'b10,
    ST_ERR2   = 2'b11
  } state_t;

endpackage

// File: rtl/ahb_be_gen.sv
// Byte-lane enables and natural-alignment check for one AHB address phase.
module ahb_be_gen
  import ahb_pkg::*;
(
  input  logic [1:0] haddr,
  input  logic [2:0] hsize,
  output logic [3:0] be,
  output logic       misalign
);

  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << haddr;
      HSIZE_HALF: begin
        be       = 4'b0011 << {haddr[1], 1'b0};
        misalign = haddr[0];
      end
      HSIZE_WORD: begin
        be       = 4'b1111;
        misalign = |haddr;
      end
      // Oversized transfers are rejected by the caller; no lanes enabled.
      default: be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_slv_resp.sv
// AHB-Lite slave front end: qualifies address phases, raises two-cycle ERROR
// responses for illegal transfers and forwards legal ones to a simple memory port.
module ahb_slv_resp
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic                hsel,
  input  logic                hready,
  input  logic [1:0]          htrans,
  input  logic [2:0]          hsize,
  input  logic                hwrite,
  input  logic [31:0]         haddr,
  input  logic [31:0]         hwdata,
  output logic                hready_resp,
  output logic [1:0]          hresp,
  output logic [31:0]         hrdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rdata
);

  localparam int unsigned WA_W = ADDR_W - 2;

  state_t          state;
  logic [WA_W-1:0] addr_q;
  logic [3:0]      be_q;
  logic            write_q;

  logic [3:0] be;
  logic       misalign;
  logic       accept;
  logic       oob;
  logic       bad;
  logic       take;
  logic       in_access;

  ahb_be_gen u_be_gen (
    .haddr    (haddr[1:0]),
    .hsize    (hsize),
    .be       (be),
    .misalign (misalign)
  );

  assign accept = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign oob    = (haddr >> ADDR_W) != 32'd0;
  assign bad    = (hsize > HSIZE_WORD) || misalign || oob;

  // A new address phase is only taken where the current data phase is completing.
  assign take = accept && ((state == ST_IDLE) || (state == ST_ERR2) ||
                           ((state == ST_ACCESS) && mem_ack));

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
    end else if (take) begin
      state   <= bad ? ST_ERR1 : ST_ACCESS;
      addr_q  <= haddr[ADDR_W-1:2];
      be_q    <= be;
      write_q <= hwrite;
    end else begin
      case (state)
        ST_ACCESS: if (mem_ack) state <= ST_IDLE;
        ST_ERR1:   state <= ST_ERR2;
        ST_ERR2:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign in_access = (state == ST_ACCESS);

  assign mem_req   = in_access;
  assign mem_we    = in_access && write_q;
  assign mem_addr  = addr_q;
  assign mem_be    = in_access ? be_q : 4'b0000;
  assign mem_wdata = hwdata;

  // Wait states come straight from the memory; ERR1 is the single stalled error cycle.
  assign hready_resp = in_access ? mem_ack : (state != ST_ERR1);
  assign hresp       = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata      = (in_access && mem_ack && !write_q) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_ahb_slv_resp.sv
// Directed bench for ahb_slv_resp with a single master whose hready is looped back.
module tb_ahb_slv_resp;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic        hready;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 hclk = ~hclk;

  // Single-slave system: the bus ready is the slave's own ready.
  assign hready = hready_resp;

  ahb_slv_resp #(.ADDR_W(16)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .hsel        (hsel),
    .hready      (hready),
    .htrans      (htrans),
    .hsize       (hsize),
    .hwrite      (hwrite),
    .haddr       (haddr),
    .hwdata      (hwdata),
    .hready_resp (hready_resp),
    .hresp       (hresp),
    .hrdata      (hrdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic addr_ph(input logic [1:0] trans, input logic write,
                         input logic [2:0] size, input logic [31:0] addr);
    hsel   = 1'b1;
    htrans = trans;
    hwrite = write;
    hsize  = size;
    haddr  = addr;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b010;
    haddr  = 32'h0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic cyc();
    @(negedge hclk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    hreset    = 1'b1;
    hwdata    = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    bus_idle();

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk("rst_hready", 32'(hready_resp), 32'd1);
      chk("rst_hresp", 32'(hresp), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_hrdata", hrdata, 32'd0);
    end

    // Zero-wait word write to 0x0010
    cyc(); hreset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    addr_ph(2'b10, 1'b1, 3'b010, 32'h0000_0010);
    settle();
    chk("wr_addr_ph_hready", 32'(hready_resp), 32'd1);
    cyc(); bus_idle(); hwdata = 32'hDEADBEEF; settle();
    chk("wr_mem_req", 32'(mem_req), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h004);
    chk("wr_mem_be", 32'(mem_be), 32'hF);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_hready", 32'(hready_resp), 32'd1);
    chk("wr_hrdata_zero", hrdata, 32'd0);
    chk("wr_hresp", 32'(hresp), 32'd0);
    cyc(); settle();
    chk("wr_done_req", 32'(mem_req), 32'd0);

    // Halfword read of 0x0022 with two wait states
    cyc(); mem_ack = 1'b0; mem_rdata = 32'hAAAAAAAA;
    addr_ph(2'b10, 1'b0, 3'b001, 32'h0000_0022);
    settle();
    cyc(); bus_idle(); settle();
    chk("rd_w1_req", 32'(mem_req), 32'd1);
    chk("rd_w1_be", 32'(mem_be), 32'hC);
    chk("rd_w1_addr", 32'(mem_addr), 32'h008);
    chk("rd_w1_we", 32'(mem_we), 32'd0);
    chk("rd_w1_hready", 32'(hready_resp), 32'd0);
    chk("rd_w1_hrdata", hrdata, 32'd0);
    cyc(); settle();
    chk("rd_w2_req", 32'(mem_req), 32'd1);
    chk("rd_w2_be", 32'(mem_be), 32'hC);
    chk("rd_w2_hready", 32'(hready_resp), 32'd0);
    cyc(); mem_ack = 1'b1; mem_rdata = 32'h12345678; settle();
    chk("rd_ack_hready", 32'(hready_resp), 32'd1);
    chk("rd_ack_hrdata", hrdata, 32'h12345678);
    cyc(); settle();
    chk("rd_done_req", 32'(mem_req), 32'd0);
    chk("rd_done_hrdata", hrdata, 32'd0);

    // Misaligned word read of 0x0003
    cyc(); addr_ph(2'b10, 1'b0, 3'b010, 32'h0000_0003); settle();
    cyc(); bus_idle(); settle();
    chk("err1_hresp", 32'(hresp), 32'd1);
    chk("err1_hready", 32'(hready_resp), 32'd0);
    chk("err1_req", 32'(mem_req), 32'd0);
    cyc(); settle();
    chk("err2_hresp", 32'(hresp), 32'd1);
    chk("err2_hready", 32'(hready_resp), 32'd1);
    chk("err2_req", 32'(mem_req), 32'd0);
    cyc(); settle();
    chk("err_idle_hresp", 32'(hresp), 32'd0);

    // Out-of-range write, then a pipelined byte read taken from ERR2
    cyc(); addr_ph(2'b10, 1'b1, 3'b010, 32'h0001_0000); settle();
    cyc(); addr_ph(2'b10, 1'b0, 3'b000, 32'h0000_0005); settle();
    chk("oob_err1_hresp", 32'(hresp), 32'd1);
    chk("oob_err1_hready", 32'(hready_resp), 32'd0);
    chk("oob_err1_req", 32'(mem_req), 32'd0);
    cyc(); settle();
    chk("oob_err2_hresp", 32'(hresp), 32'd1);
    chk("oob_err2_hready", 32'(hready_resp), 32'd1);
    cyc(); bus_idle(); mem_rdata = 32'h55667788; settle();
    chk("pipe_req", 32'(mem_req), 32'd1);
    chk("pipe_be", 32'(mem_be), 32'h2);
    chk("pipe_addr", 32'(mem_addr), 32'h001);
    chk("pipe_hresp", 32'(hresp), 32'd0);
    chk("pipe_hrdata", hrdata, 32'h55667788);
    cyc(); settle();
    chk("pipe_done_req", 32'(mem_req), 32'd0);

    // Back-to-back zero-wait writes accepted from ACCESS
    cyc(); addr_ph(2'b10, 1'b1, 3'b010, 32'h0000_0004); settle();
    cyc(); addr_ph(2'b11, 1'b1, 3'b001, 32'h0000_0006); hwdata = 32'h11111111; settle();
    chk("b2b_1_be", 32'(mem_be), 32'hF);
    chk("b2b_1_wdata", mem_wdata, 32'h11111111);
    cyc(); bus_idle(); hwdata = 32'h22222222; settle();
    chk("b2b_2_req", 32'(mem_req), 32'd1);
    chk("b2b_2_be", 32'(mem_be), 32'hC);
    chk("b2b_2_addr", 32'(mem_addr), 32'h001);
    chk("b2b_2_wdata", mem_wdata, 32'h22222222);
    cyc(); settle();
    chk("b2b_done_req", 32'(mem_req), 32'd0);

    // Reset during the second wait state of a read
    cyc(); mem_ack = 1'b0; addr_ph(2'b10, 1'b0, 3'b010, 32'h0000_0040); settle();
    cyc(); bus_idle(); settle();
    chk("rr_w1_req", 32'(mem_req), 32'd1);
    cyc(); hreset = 1'b1; settle();
    chk("rr_w2_req", 32'(mem_req), 32'd1);
    cyc(); hreset = 1'b0; settle();
    chk("rr_after_req", 32'(mem_req), 32'd0);
    chk("rr_after_hready", 32'(hready_resp), 32'd1);
    cyc(); settle();
    chk("rr_idle_req", 32'(mem_req), 32'd0);
    chk("rr_idle_hresp", 32'(hresp), 32'd0);
    cyc(); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    addr_ph(2'b10, 1'b0, 3'b000, 32'h0000_0043); settle();
    cyc(); bus_idle(); settle();
    chk("rr_new_req", 32'(mem_req), 32'd1);
    chk("rr_new_be", 32'(mem_be), 32'h8);
    chk("rr_new_addr", 32'(mem_addr), 32'h010);
    chk("rr_new_hrdata", hrdata, 32'hCAFEF00D);
    cyc(); settle();
    chk("rr_new_done", 32'(mem_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
